// File: rtl/iterative_alu.sv
// iterative_alu: clocked ALU with start/done handshake, shift-add multiplier and restoring divider.
module iterative_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_NAND = 4'b1101, OP_MULU = 4'b0011,
                         OP_DIVU = 4'b1010, OP_REMU = 4'b1011;
  logic [1:0]         st;
  logic [3:0]         opq;
  logic [WIDTH-1:0]   aq, bq, sum, dif, ex_res, it_res, dsub;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mstep, dshift;
  logic               ovf_add, ovf_sub, ex_ovf, it_ovf, iter_op, last, ge;
  assign busy    = st != IDLE;
  assign iter_op = op == OP_MULU || ((op == OP_DIVU || op == OP_REMU) && b != '0);
  assign sum     = aq + bq;
  assign dif     = aq - bq;
  assign ovf_add = (aq[WIDTH-1] == bq[WIDTH-1]) && (sum[WIDTH-1] != aq[WIDTH-1]);
  assign ovf_sub = (aq[WIDTH-1] != bq[WIDTH-1]) && (dif[WIDTH-1] != aq[WIDTH-1]);
  // multiplier: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mstep   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, aq} : '0);
  // divider: acc = {partial remainder, remaining dividend / quotient bits}, shifted left each step
  assign dshift  = acc[2*WIDTH-1:WIDTH-1];
  assign ge      = dshift >= {1'b0, bq};
  assign dsub    = ge ? WIDTH'(dshift - {1'b0, bq}) : dshift[WIDTH-1:0];
  assign last    = cnt == CW'(WIDTH);
  assign it_res  = opq == OP_REMU ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
  assign it_ovf  = opq == OP_MULU && |acc[2*WIDTH-1:WIDTH];
  always_comb begin
    ex_res = '0;
    ex_ovf = 1'b0;
    case (opq)
      OP_AND:  ex_res = aq & bq;
      OP_OR:   ex_res = aq | bq;
      OP_NOR:  ex_res = ~(aq | bq);
      OP_NAND: ex_res = ~(aq & bq);
      OP_ADD:  begin ex_res = sum; ex_ovf = ovf_add; end
      OP_SUB:  begin ex_res = dif; ex_ovf = ovf_sub; end
      OP_SLT:  ex_res = WIDTH'(dif[WIDTH-1] ^ ovf_sub);
      OP_DIVU: begin ex_res = '1; ex_ovf = 1'b1; end
      OP_REMU: begin ex_res = aq; ex_ovf = 1'b1; end
      default: ex_res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      opq      <= '0;
      aq       <= '0;
      bq       <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          opq <= op;
          aq  <= a;
          bq  <= b;
          acc <= {{WIDTH{1'b0}}, op == OP_MULU ? b : a};
          cnt <= '0;
          st  <= iter_op ? ITER : EXEC;
        end
        EXEC: begin
          result   <= ex_res;
          zero     <= ex_res == '0;
          overflow <= ex_ovf;
          done     <= 1'b1;
          st       <= IDLE;
        end
        ITER: if (last) begin
          result   <= it_res;
          zero     <= it_res == '0;
          overflow <= it_ovf;
          done     <= 1'b1;
          st       <= IDLE;
        end else begin
          acc <= opq == OP_MULU ? {mstep, acc[WIDTH-1:1]} : {dsub, acc[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed checks of iterative_alu at WIDTH 16, 8 and 32.
module tb_iterative_alu;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111,
                         NOR_ = 4'b1100, NAND_ = 4'b1101, MULU = 4'b0011, DIVU = 4'b1010, REMU = 4'b1011;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [3:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic [2:0]  busy, done, zero, ovf;
  logic [15:0] r16;
  logic [7:0]  r8;
  logic [31:0] r32;
  int          cur = 0, checks = 0, failures = 0;
  logic        busy_s, done_s, zero_s, ovf_s;
  logic [63:0] res_s;
  iterative_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(start[0]), .op(op), .a(a[15:0]),
    .b(b[15:0]), .busy(busy[0]), .done(done[0]), .result(r16), .zero(zero[0]), .overflow(ovf[0]));
  iterative_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start[1]), .op(op), .a(a[7:0]),
    .b(b[7:0]), .busy(busy[1]), .done(done[1]), .result(r8), .zero(zero[1]), .overflow(ovf[1]));
  iterative_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(start[2]), .op(op), .a(a[31:0]),
    .b(b[31:0]), .busy(busy[2]), .done(done[2]), .result(r32), .zero(zero[2]), .overflow(ovf[2]));
  always #5 clk = ~clk;
  always_comb begin
    busy_s = busy[cur];
    done_s = done[cur];
    zero_s = zero[cur];
    ovf_s  = ovf[cur];
    res_s  = cur == 1 ? {56'b0, r8} : cur == 2 ? {32'b0, r32} : {48'b0, r16};
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int sel, input string tag, input logic [3:0] o, input logic [63:0] av,
                     input logic [63:0] bv, input logic [63:0] er, input logic ez, input logic eo,
                     input int el, input bit disturb);
    int lat;
    logic busy_ok;
    cur = sel;
    op = o; a = av; b = bv;
    start[sel] = 1'b1;
    @(posedge clk);
    #1 start[sel] = 1'b0;
    busy_ok = busy_s;
    lat = 0;
    while (!done_s && lat < 100) begin
      if (disturb && lat == 2) begin
        op = AND_; a = 64'd1; b = 64'd1; start[sel] = 1'b1;
      end else start[sel] = 1'b0;
      @(posedge clk);
      #1 lat++;
      if (!done_s) busy_ok &= busy_s;
    end
    start[sel] = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " result"}, res_s, er);
    chk({tag, " zero"}, 64'(zero_s), 64'(ez));
    chk({tag, " overflow"}, 64'(ovf_s), 64'(eo));
    chk({tag, " busy"}, {62'b0, busy_ok, busy_s}, 64'b10);
  endtask
  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", {busy[0], done[0], zero[0], ovf[0], 16'(r16)}, '0);
    chk("reset8", {busy[1], done[1], zero[1], ovf[1], 8'(r8)}, '0);
    chk("reset32", {busy[2], done[2], zero[2], ovf[2], r32}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, "and16", AND_, 64'h000C, 64'h0018, 64'h0008, 0, 0, 1, 0);
    run(0, "nand16", NAND_, 64'h000C, 64'h0018, 64'hFFF7, 0, 0, 1, 0);
    run(0, "or16", OR_, 64'h00F0, 64'h0F00, 64'h0FF0, 0, 0, 1, 0);
    run(0, "nor16", NOR_, 64'h0000, 64'h0000, 64'hFFFF, 0, 0, 1, 0);
    run(0, "add16", ADD, 64'h7FFF, 64'h0001, 64'h8000, 0, 1, 1, 0);
    run(0, "sub16z", SUB, 64'h0005, 64'h0005, 64'h0000, 1, 0, 1, 0);
    run(0, "sub16", SUB, 64'hFFFF, 64'h8000, 64'h7FFF, 0, 0, 1, 0);
    run(0, "slt16a", SLT, 64'h8000, 64'h0001, 64'h0001, 0, 0, 1, 0);
    run(0, "slt16b", SLT, 64'h0005, 64'hFFFF, 64'h0000, 1, 0, 1, 0);
    run(0, "bad16", 4'b0100, 64'h0001, 64'h0001, 64'h0000, 1, 0, 1, 0);
    run(0, "mulu16", MULU, 64'd300, 64'd300, 64'h5F90, 0, 1, 17, 0);
    run(0, "mulu16b", MULU, 64'h00FF, 64'h0101, 64'hFFFF, 0, 0, 17, 0);
    run(0, "mulu16i", MULU, 64'd300, 64'd300, 64'h5F90, 0, 1, 17, 1);
    run(0, "divu16", DIVU, 64'd100, 64'd7, 64'd14, 0, 0, 17, 0);
    run(0, "remu16", REMU, 64'd100, 64'd7, 64'd2, 0, 0, 17, 0);
    run(0, "divz16", DIVU, 64'd5, 64'd0, 64'hFFFF, 0, 1, 1, 0);
    run(0, "remz16", REMU, 64'd5, 64'd0, 64'd5, 0, 1, 1, 0);
    run(1, "add8", ADD, 64'h7F, 64'h01, 64'h80, 0, 1, 1, 0);
    run(1, "slt8", SLT, 64'h80, 64'h01, 64'h01, 0, 0, 1, 0);
    run(1, "mulu8", MULU, 64'd20, 64'd20, 64'h90, 0, 1, 9, 0);
    run(1, "divu8", DIVU, 64'd100, 64'd7, 64'd14, 0, 0, 9, 0);
    run(1, "divz8", DIVU, 64'd5, 64'd0, 64'hFF, 0, 1, 1, 0);
    run(2, "add32", ADD, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 0, 1, 1, 0);
    run(2, "mulu32", MULU, 64'd300, 64'd300, 64'h15F90, 0, 0, 33, 0);
    run(2, "mulu32o", MULU, 64'h1_0000, 64'h1_0000, 64'h0, 1, 1, 33, 0);
    run(2, "divu32", DIVU, 64'hFFFF_FFFF, 64'd16, 64'h0FFF_FFFF, 0, 0, 33, 0);
    run(2, "remu32", REMU, 64'hFFFF_FFFF, 64'd16, 64'hF, 0, 0, 33, 0);
    cur = 0;
    op = DIVU; a = 64'd100; b = 64'd7;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midreset", {busy[0], done[0], zero[0], ovf[0], 16'(r16)}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1 seen |= done[0];
    end
    chk("midreset nodone", 64'(seen), 64'd0);
    chk("midreset hold", {busy[0], 16'(r16)}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
